// File: rtl/lsu_mem_ctrl.sv
// Load/store front-end for the byte-addressed data memory.
// It aligns addresses, lane-shifts store data and strobes, and extracts and extends load results.
module lsu_mem_ctrl #(
    parameter int unsigned xlen    = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_v,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [xlen-1:0] req_adr,
    input  logic [xlen-1:0] req_wdata,
    output logic            resp_v,
    output logic [xlen-1:0] resp_data,
    output logic            resp_err,
    output logic            mem_r_v,
    output logic            mem_w_v,
    output logic [xlen-1:0] mem_adr,
    output logic [xlen-1:0] mem_data,
    output logic [3:0]      mem_strobe,
    input  logic [xlen-1:0] mem_resp,
    input  logic            mem_ack
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       off_q;
    logic [1:0]       size_q;
    logic             uns_q;

    logic             misalign_c;
    logic [3:0]       wr_strobe_c;
    logic [xlen-1:0]  wr_data_c;
    logic [xlen-1:0]  rd_shift_c;
    logic [xlen-1:0]  rd_data_c;

    // Request decode straight off the execute-stage inputs
    always_comb begin
        misalign_c  = (req_size == 2'd3) ||
                      (req_size == 2'd1 && req_adr[0]) ||
                      (req_size == 2'd2 && req_adr[1:0] != 2'd0);
        wr_strobe_c = 4'b1111;
        wr_data_c   = req_wdata;
        case (req_size)
            2'd0: begin
                wr_strobe_c = 4'b0001 << req_adr[1:0];
                wr_data_c   = xlen'(req_wdata[7:0]) << {req_adr[1:0], 3'b000};
            end
            2'd1: begin
                wr_strobe_c = 4'b0011 << req_adr[1:0];
                wr_data_c   = xlen'(req_wdata[15:0]) << {req_adr[1:0], 3'b000};
            end
            default: ;
        endcase
    end

    // Load lane extraction and sign/zero extension from the latched request
    always_comb begin
        rd_shift_c = mem_resp >> {off_q, 3'b000};
        case (size_q)
            2'd0:    rd_data_c = {{(xlen-8){~uns_q & rd_shift_c[7]}}, rd_shift_c[7:0]};
            2'd1:    rd_data_c = {{(xlen-16){~uns_q & rd_shift_c[15]}}, rd_shift_c[15:0]};
            default: rd_data_c = rd_shift_c;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            off_q      <= 2'd0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            req_ready  <= 1'b1;
            resp_v     <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            mem_r_v    <= 1'b0;
            mem_w_v    <= 1'b0;
            mem_adr    <= '0;
            mem_data   <= '0;
            mem_strobe <= 4'd0;
        end else begin
            resp_v <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_v) begin
                        req_ready <= 1'b0;
                        off_q     <= req_adr[1:0];
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        cnt       <= '0;
                        if (misalign_c) begin
                            state     <= RESP;
                            resp_v    <= 1'b1;
                            resp_err  <= 1'b1;
                            resp_data <= '0;
                        end else if (req_we) begin
                            state      <= WR;
                            mem_w_v    <= 1'b1;
                            mem_adr    <= {req_adr[xlen-1:2], 2'b00};
                            mem_data   <= wr_data_c;
                            mem_strobe <= wr_strobe_c;
                        end else begin
                            state      <= RD;
                            mem_r_v    <= 1'b1;
                            mem_adr    <= {req_adr[xlen-1:2], 2'b00};
                            mem_data   <= '0;
                            mem_strobe <= 4'd0;
                        end
                    end
                end
                WR: begin
                    state      <= RESP;
                    mem_w_v    <= 1'b0;
                    mem_adr    <= '0;
                    mem_data   <= '0;
                    mem_strobe <= 4'd0;
                    resp_v     <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_data  <= '0;
                end
                RD: begin
                    cnt <= cnt + CNT_W'(1);
                    // First RD cycle skips ack: a level left high from before the request is stale
                    if (cnt != '0 && mem_ack) begin
                        state     <= RESP;
                        mem_r_v   <= 1'b0;
                        mem_adr   <= '0;
                        resp_v    <= 1'b1;
                        resp_err  <= 1'b0;
                        resp_data <= rd_data_c;
                    end else if (cnt == CNT_LAST) begin
                        state     <= RESP;
                        mem_r_v   <= 1'b0;
                        mem_adr   <= '0;
                        resp_v    <= 1'b1;
                        resp_err  <= 1'b1;
                        resp_data <= '0;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    resp_err  <= 1'b0;
                    resp_data <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized self-checking bench for lsu_mem_ctrl against a byte-lane reference model.
module tb_lsu_mem_ctrl;

    localparam int unsigned TMO = 4;

    logic        clk;
    logic        rst;
    logic        req_v;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_adr;
    logic [31:0] req_wdata;
    logic        resp_v;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        mem_r_v;
    logic        mem_w_v;
    logic [31:0] mem_adr;
    logic [31:0] mem_data;
    logic [3:0]  mem_strobe;
    logic [31:0] mem_resp;
    logic        mem_ack;

    int errors = 0;
    int checks = 0;

    lsu_mem_ctrl #(.xlen(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_v(req_v), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_adr(req_adr), .req_wdata(req_wdata),
        .resp_v(resp_v), .resp_data(resp_data), .resp_err(resp_err),
        .mem_r_v(mem_r_v), .mem_w_v(mem_w_v), .mem_adr(mem_adr), .mem_data(mem_data),
        .mem_strobe(mem_strobe), .mem_resp(mem_resp), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_legal(input logic [31:0] adr, input logic [1:0] size);
        return (size == 2'd0) || (size == 2'd1 && adr[0] == 1'b0) ||
               (size == 2'd2 && adr[1:0] == 2'd0);
    endfunction

    // Memory-side view of a store: which bytes get written, and with what
    function automatic void model_store(input logic [31:0] adr, input logic [1:0] size,
                                        input logic [31:0] wd, output logic [3:0] stb,
                                        output logic [31:0] dat);
        int off;
        off = int'(adr[1:0]);
        stb = 4'd0;
        dat = 32'd0;
        for (int i = 0; i < nbytes(size); i++) begin
            stb[off+i]         = 1'b1;
            dat[8*(off+i) +: 8] = wd[8*i +: 8];
        end
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] adr,
                                               input logic [1:0] size, input logic uns);
        logic [31:0] v;
        int off;
        int n;
        off = int'(adr[1:0]);
        n   = nbytes(size);
        v   = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
        if (!uns && n < 4 && v[8*n-1])
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic test_reset();
        clk = 0; rst = 1; req_v = 0; req_we = 0; req_size = 0; req_unsigned = 0;
        req_adr = 0; req_wdata = 0; mem_resp = 0; mem_ack = 0;
        #12;
        checks++; if ({req_ready, resp_v, resp_err, mem_r_v, mem_w_v} !== 5'b10000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 10000", {req_ready, resp_v, resp_err, mem_r_v, mem_w_v});
        end
        checks++; if ({mem_adr, mem_data, resp_data, mem_strobe} !== 100'd0) begin
            errors++; $display("FAIL reset_data: adr %h data %h rdata %h stb %b want 0", mem_adr, mem_data, resp_data, mem_strobe);
        end
        @(posedge clk); #1; rst = 0;
        @(posedge clk); #1;
        checks++; if ({req_ready, resp_v, mem_r_v, mem_w_v} !== 4'b1000) begin
            errors++; $display("FAIL post_reset: got %b want 1000", {req_ready, resp_v, mem_r_v, mem_w_v});
        end
    endtask

    // Called just after a posedge with the controller idle
    task automatic run_store(input logic [31:0] adr, input logic [1:0] size,
                             input logic [31:0] wd, input bit hold);
        logic [3:0]  stb;
        logic [31:0] dat;
        model_store(adr, size, wd, stb, dat);
        checks++; if (req_ready !== 1'b1) begin
            errors++; $display("FAIL st_ready: got %b want 1", req_ready);
        end
        req_v = 1; req_we = 1; req_size = size; req_adr = adr; req_wdata = wd; req_unsigned = 0;
        @(posedge clk); #1;
        if (hold) begin req_adr = $urandom; req_wdata = $urandom; end
        else req_v = 0;
        checks++; if ({mem_w_v, mem_r_v, req_ready, resp_v} !== 4'b1000) begin
            errors++; $display("FAIL st_wr_ctrl: got %b want 1000", {mem_w_v, mem_r_v, req_ready, resp_v});
        end
        checks++; if ({mem_adr, mem_data, mem_strobe} !== {adr & 32'hFFFF_FFFC, dat, stb}) begin
            errors++; $display("FAIL st_wr_bus: adr %h data %h stb %b want %h %h %b",
                               mem_adr, mem_data, mem_strobe, adr & 32'hFFFF_FFFC, dat, stb);
        end
        @(posedge clk); #1;
        checks++; if ({mem_w_v, mem_r_v, resp_v, resp_err, req_ready} !== 5'b00100 || resp_data !== 32'd0) begin
            errors++; $display("FAIL st_resp: got %b data %h want 00100 data 0",
                               {mem_w_v, mem_r_v, resp_v, resp_err, req_ready}, resp_data);
        end
        @(posedge clk); #1;
        req_v = 0;
        checks++; if ({resp_v, req_ready} !== 2'b01) begin
            errors++; $display("FAIL st_done: got %b want 01", {resp_v, req_ready});
        end
    endtask

    task automatic run_err(input logic [31:0] adr, input logic [1:0] size, input logic we);
        checks++; if (req_ready !== 1'b1) begin
            errors++; $display("FAIL er_ready: got %b want 1", req_ready);
        end
        req_v = 1; req_we = we; req_size = size; req_adr = adr; req_wdata = $urandom;
        @(posedge clk); #1; req_v = 0;
        checks++; if ({resp_v, resp_err, mem_r_v, mem_w_v, req_ready} !== 5'b11000 || resp_data !== 32'd0) begin
            errors++; $display("FAIL er_resp: got %b data %h want 11000 data 0",
                               {resp_v, resp_err, mem_r_v, mem_w_v, req_ready}, resp_data);
        end
        @(posedge clk); #1;
        checks++; if ({resp_v, mem_r_v, mem_w_v, req_ready} !== 4'b0001) begin
            errors++; $display("FAIL er_done: got %b want 0001", {resp_v, mem_r_v, mem_w_v, req_ready});
        end
    endtask

    // ack_edge: RD edge index from which memory raises ack (0 = never); stale: ack high throughout
    task automatic run_load(input logic [31:0] adr, input logic [1:0] size, input logic uns,
                            input int ack_edge, input bit stale, input bit fixed,
                            input logic [31:0] fixed_val);
        logic [31:0] w;
        bit done;
        checks++; if (req_ready !== 1'b1) begin
            errors++; $display("FAIL ld_ready: got %b want 1", req_ready);
        end
        mem_ack = stale;
        req_v = 1; req_we = 0; req_size = size; req_adr = adr; req_unsigned = uns;
        @(posedge clk); #1; req_v = 0;
        checks++; if ({mem_r_v, mem_w_v, req_ready, resp_v, mem_strobe} !== 8'b1000_0000 ||
                      mem_adr !== (adr & 32'hFFFF_FFFC)) begin
            errors++; $display("FAIL ld_issue: got %b adr %h want 10000000 adr %h",
                               {mem_r_v, mem_w_v, req_ready, resp_v, mem_strobe}, mem_adr, adr & 32'hFFFF_FFFC);
        end
        done = 0;
        for (int e = 1; e <= int'(TMO) && !done; e++) begin
            @(negedge clk);
            w = fixed ? fixed_val : $urandom;
            mem_resp = w;
            if (ack_edge != 0 && e >= ack_edge) mem_ack = 1;
            @(posedge clk); #1;
            if (e >= 2 && mem_ack) begin
                done = 1;
                checks++; if ({resp_v, resp_err, mem_r_v} !== 3'b100 || resp_data !== model_load(w, adr, size, uns)) begin
                    errors++; $display("FAIL ld_data: edge %0d got %b data %h want 100 data %h",
                                       e, {resp_v, resp_err, mem_r_v}, resp_data, model_load(w, adr, size, uns));
                end
            end else if (e == int'(TMO)) begin
                done = 1;
                checks++; if ({resp_v, resp_err, mem_r_v} !== 3'b110 || resp_data !== 32'd0) begin
                    errors++; $display("FAIL ld_timeout: got %b data %h want 110 data 0",
                                       {resp_v, resp_err, mem_r_v}, resp_data);
                end
            end else begin
                checks++; if ({resp_v, mem_r_v, req_ready} !== 3'b010) begin
                    errors++; $display("FAIL ld_wait: edge %0d got %b want 010", e, {resp_v, mem_r_v, req_ready});
                end
            end
        end
        mem_ack = 0;
        @(posedge clk); #1;
        checks++; if ({resp_v, mem_r_v, req_ready} !== 3'b001) begin
            errors++; $display("FAIL ld_done: got %b want 001", {resp_v, mem_r_v, req_ready});
        end
    endtask

    task automatic test_directed();
        run_store(32'h0000_0103, 2'd0, 32'h0000_00AB, 0);
        run_store(32'h0000_0202, 2'd1, 32'hDEAD_BEEF, 0);
        run_store(32'h0000_0300, 2'd2, 32'h1234_5678, 0);
        run_load(32'h0000_0102, 2'd1, 1'b0, 2, 0, 1, 32'h8001_1234);
        run_load(32'h0000_0102, 2'd1, 1'b1, 2, 0, 1, 32'h8001_1234);
        run_load(32'h0000_0101, 2'd0, 1'b0, 3, 0, 1, 32'h1234_9A56);
        run_err(32'h0000_0006, 2'd2, 1'b0);
        run_err(32'h0000_0011, 2'd1, 1'b1);
        run_err(32'h0000_0010, 2'd3, 1'b0);
    endtask

    task automatic test_stale_ack();
        run_load(32'h0000_0040, 2'd2, 1'b0, 0, 1, 0, 32'd0);
        run_load(32'h0000_0043, 2'd0, 1'b0, 1, 0, 0, 32'd0);
    endtask

    task automatic test_timeout();
        run_load(32'h0000_0080, 2'd2, 1'b0, 0, 0, 0, 32'd0);
        run_load(32'h0000_0084, 2'd2, 1'b0, int'(TMO), 0, 0, 32'd0);
    endtask

    task automatic test_back_to_back();
        run_store(32'h0000_0500, 2'd2, 32'hCAFE_F00D, 1);
        run_store(32'h0000_0501, 2'd0, 32'h0000_0077, 1);
    endtask

    task automatic test_reset_mid_rd();
        mem_ack = 0;
        req_v = 1; req_we = 0; req_size = 2'd2; req_adr = 32'h0000_0080; req_unsigned = 0;
        @(posedge clk); #1; req_v = 0;
        checks++; if (mem_r_v !== 1'b1) begin
            errors++; $display("FAIL rst_rd_pre: got %b want 1", mem_r_v);
        end
        #2; rst = 1; #1;
        checks++; if ({mem_r_v, req_ready, resp_v} !== 3'b010) begin
            errors++; $display("FAIL rst_rd_async: got %b want 010", {mem_r_v, req_ready, resp_v});
        end
        @(posedge clk); #1; rst = 0; mem_ack = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++; if ({resp_v, mem_r_v, req_ready} !== 3'b001) begin
                errors++; $display("FAIL rst_rd_quiet: cycle %0d got %b want 001", i, {resp_v, mem_r_v, req_ready});
            end
        end
        mem_ack = 0;
        run_load(32'h0000_0088, 2'd1, 1'b0, 1, 0, 0, 32'd0);
    endtask

    task automatic test_random();
        logic [31:0] adr;
        logic [1:0]  size;
        int          r;
        for (int k = 0; k < 60; k++) begin
            adr  = $urandom;
            size = 2'($urandom_range(0, 3));
            r    = $urandom_range(0, 9);
            if (!is_legal(adr, size)) run_err(adr, size, 1'($urandom_range(0, 1)));
            else if ($urandom_range(0, 1) == 1) run_store(adr, size, $urandom, 0);
            else run_load(adr, size, 1'($urandom_range(0, 1)), (r == 0) ? 0 : 1 + (r % int'(TMO)),
                          r == 9, 0, 32'd0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stale_ack();
        test_timeout();
        test_back_to_back();
        test_reset_mid_rd();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
